// File: rtl/cook_scheduler_pkg.sv
// Shared definitions for the microwave cook scheduler.
//   - state_t      : controller states IDLE / COOK / PAUSE / DONE
//   - BCD_W        : width of one BCD digit
//   - TIME_W       : width of the packed MM:SS time word {M1, M0, S1, S0}
//   - MAX_MINUTES  : largest minute value that may be loaded
//   - BTN_*        : bit positions of the buttons in the packed button vector
//   - mmss_valid() : legality check for a loaded MM:SS value
package cook_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COOK  = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int BCD_W       = 4;
    localparam int TIME_W      = 4 * BCD_W;
    localparam int MAX_MINUTES = 99;

    localparam int BTN_START = 0;
    localparam int BTN_STOP  = 1;
    localparam int BTN_CLEAR = 2;
    localparam int BTN_N     = 3;

    // Every digit must be a decimal digit and the seconds tens digit at most 5.
    function automatic logic mmss_valid(input logic [TIME_W-1:0] t);
        logic ok;
        ok = (t[3:0]   <= 4'd9) &&
             (t[7:4]   <= 4'd5) &&
             (t[11:8]  <= 4'd9) &&
             (t[15:12] <= 4'd9) &&
             ((int'(t[15:12]) * 10 + int'(t[11:8])) <= MAX_MINUTES);
        return ok;
    endfunction

endpackage

// File: rtl/cook_scheduler_if.sv
// Panel-side bus of the cook scheduler.
//   Inputs to the scheduler : tick, startn, stopn, clearn (active-low),
//                             door_closed, load, time_in, power_in
//   Outputs of the scheduler: time_bcd, mag_on, timer_done, done,
//                             cooking, paused
//   Modports: master = oven panel / testbench, slave = scheduler.
// power_in exists only when COOK_SCHED_POWER_EN is defined.
interface cook_if;
    import cook_pkg::*;

    logic              tick;
    logic              startn;
    logic              stopn;
    logic              clearn;
    logic              door_closed;
    logic              load;
    logic [TIME_W-1:0] time_in;
`ifdef COOK_SCHED_POWER_EN
    logic [3:0]        power_in;
`endif
    logic [TIME_W-1:0] time_bcd;
    logic              mag_on;
    logic              timer_done;
    logic              done;
    logic              cooking;
    logic              paused;

    modport master (
`ifdef COOK_SCHED_POWER_EN
        output power_in,
`endif
        output tick, startn, stopn, clearn, door_closed, load, time_in,
        input  time_bcd, mag_on, timer_done, done, cooking, paused
    );

    modport slave (
`ifdef COOK_SCHED_POWER_EN
        input  power_in,
`endif
        input  tick, startn, stopn, clearn, door_closed, load, time_in,
        output time_bcd, mag_on, timer_done, done, cooking, paused
    );

endinterface

// File: rtl/cook_scheduler_bcd_mmss_dec.sv
// Combinational one-second decrement of a BCD MM:SS value.
//   mmss     : current time {M1, M0, S1, S0}
//   mmss_dec : time minus one second (saturates at 00:00)
//   zero     : mmss_dec is 00:00
module bcd_mmss_dec
    import cook_pkg::*;
(
    input  logic [TIME_W-1:0] mmss,
    output logic [TIME_W-1:0] mmss_dec,
    output logic              zero
);

    logic [BCD_W-1:0] d  [4];
    logic [BCD_W-1:0] nd [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
        assign d[gi] = mmss[gi*BCD_W +: BCD_W];
        assign mmss_dec[gi*BCD_W +: BCD_W] = nd[gi];
    end

    // Borrow ripples up through S0 -> S1 -> M0 -> M1; seconds wrap to 59.
    always_comb begin
        nd = d;
        if (d[0] != '0) begin
            nd[0] = d[0] - 1'b1;
        end else if (d[1] != '0) begin
            nd[1] = d[1] - 1'b1;
            nd[0] = BCD_W'(9);
        end else if (d[2] != '0) begin
            nd[2] = d[2] - 1'b1;
            nd[1] = BCD_W'(5);
            nd[0] = BCD_W'(9);
        end else if (d[3] != '0) begin
            nd[3] = d[3] - 1'b1;
            nd[2] = BCD_W'(9);
            nd[1] = BCD_W'(5);
            nd[0] = BCD_W'(9);
        end
    end

    assign zero = (mmss_dec == '0);

endmodule

// File: rtl/cook_scheduler.sv
// Microwave cook scheduler: holds the BCD MM:SS cook time, counts it down on
// the 1 Hz tick, gates the magnetron through a power duty window and
// arbitrates start/stop/clear buttons and the door switch.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : cook_if.slave (buttons, door, load/time_in, power_in,
//           time_bcd, mag_on, timer_done, done, cooking, paused)
// Parameters: DUTY_WINDOW (duty window length in ticks), DONE_HOLD (ticks the
// done indication is held).
// Build option: COOK_SCHED_POWER_EN enables the power duty window; without it
// the magnetron runs at full power whenever cooking with the door closed.
module cook_scheduler
    import cook_pkg::*;
#(
    parameter int DUTY_WINDOW = 10,
    parameter int DONE_HOLD   = 3
) (
    input  logic  clk,
    input  logic  reset,
    cook_if.slave bus
);

    localparam int               HW        = (DONE_HOLD > 1) ? $clog2(DONE_HOLD) : 1;
    localparam logic [HW-1:0]    HOLD_LAST = HW'(DONE_HOLD - 1);

    state_t            state_reg, state_next;
    logic [TIME_W-1:0] time_reg, time_next;
    logic [HW-1:0]     hold_reg, hold_next;
    logic              timer_done_reg, timer_done_next;

    // Buttons are registered once, then compared with their previous
    // registered value; a press is a 1->0 edge of the registered level.
    logic [BTN_N-1:0]  btn_in;
    logic [BTN_N-1:0]  btn_reg, btn_prev_reg;
    logic [BTN_N-1:0]  press;

    assign btn_in = {bus.clearn, bus.stopn, bus.startn};

    for (genvar gi = 0; gi < BTN_N; gi++) begin : g_press
        assign press[gi] = btn_prev_reg[gi] & ~btn_reg[gi];
    end

    logic [TIME_W-1:0] time_dec;
    logic              dec_zero;

    bcd_mmss_dec u_dec (
        .mmss     (time_reg),
        .mmss_dec (time_dec),
        .zero     (dec_zero)
    );

`ifdef COOK_SCHED_POWER_EN
    localparam int            CW      = $clog2(DUTY_WINDOW + 1);
    localparam logic [CW-1:0] DW_FULL = CW'(DUTY_WINDOW);
    localparam logic [CW-1:0] DW_LAST = CW'(DUTY_WINDOW - 1);

    logic [CW-1:0] duty_reg, duty_next;
    logic [CW-1:0] power_reg, power_next;
    logic [CW-1:0] power_clamped;

    // Out-of-range power requests (0 or beyond the window) mean full power.
    assign power_clamped = (bus.power_in == 4'd0 || {28'd0, bus.power_in} > 32'(DUTY_WINDOW))
                           ? DW_FULL : CW'(bus.power_in);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            time_reg       <= '0;
            hold_reg       <= '0;
            timer_done_reg <= 1'b0;
            btn_reg        <= '1;
            btn_prev_reg   <= '1;
`ifdef COOK_SCHED_POWER_EN
            duty_reg       <= '0;
            power_reg      <= DW_FULL;
`endif
        end else begin
            state_reg      <= state_next;
            time_reg       <= time_next;
            hold_reg       <= hold_next;
            timer_done_reg <= timer_done_next;
            btn_reg        <= btn_in;
            btn_prev_reg   <= btn_reg;
`ifdef COOK_SCHED_POWER_EN
            duty_reg       <= duty_next;
            power_reg      <= power_next;
`endif
        end
    end

    // Event priority inside every state: clear > stop > door open > start.
    always_comb begin
        state_next      = state_reg;
        time_next       = time_reg;
        hold_next       = hold_reg;
        timer_done_next = 1'b0;
`ifdef COOK_SCHED_POWER_EN
        duty_next       = duty_reg;
        power_next      = power_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (press[BTN_CLEAR]) begin
                    time_next = '0;
                end else if (press[BTN_START] && !press[BTN_STOP] &&
                             bus.door_closed && time_reg != '0) begin
                    state_next = COOK;
`ifdef COOK_SCHED_POWER_EN
                    duty_next  = '0;
                    power_next = power_clamped;
`endif
                end else if (bus.load && mmss_valid(bus.time_in)) begin
                    time_next = bus.time_in;
                end
            end
            COOK: begin
                // A button or door exit swallows a coincident tick.
                if (press[BTN_CLEAR]) begin
                    state_next = IDLE;
                    time_next  = '0;
                end else if (press[BTN_STOP] || !bus.door_closed) begin
                    state_next = PAUSE;
                end else if (bus.tick) begin
                    time_next = time_dec;
`ifdef COOK_SCHED_POWER_EN
                    duty_next = (duty_reg == DW_LAST) ? '0 : duty_reg + 1'b1;
`endif
                    if (dec_zero) begin
                        state_next      = DONE;
                        timer_done_next = 1'b1;
                        hold_next       = '0;
                    end
                end
            end
            PAUSE: begin
                if (press[BTN_CLEAR] || press[BTN_STOP]) begin
                    state_next = IDLE;
                    time_next  = '0;
                end else if (press[BTN_START] && bus.door_closed) begin
                    state_next = COOK;
                end
            end
            DONE: begin
                if (press != '0) begin
                    state_next = IDLE;
                    hold_next  = '0;
                end else if (bus.tick) begin
                    if (hold_reg == HOLD_LAST) begin
                        state_next = IDLE;
                        hold_next  = '0;
                    end else begin
                        hold_next = hold_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // mag_on uses the live door level so an opening door cuts power at once.
`ifdef COOK_SCHED_POWER_EN
    assign bus.mag_on = (state_reg == COOK) && bus.door_closed && (duty_reg < power_reg);
`else
    // A degenerate zero-length window never energises the magnetron.
    localparam logic WINDOW_OK = (DUTY_WINDOW > 0);
    assign bus.mag_on = (state_reg == COOK) && bus.door_closed && WINDOW_OK;
`endif

    assign bus.time_bcd   = time_reg;
    assign bus.timer_done = timer_done_reg;
    assign bus.done       = (state_reg == DONE);
    assign bus.cooking    = (state_reg == COOK);
    assign bus.paused     = (state_reg == PAUSE);

endmodule

// File: tb/tb_cook_scheduler.sv
// Directed self-checking bench for cook_scheduler (DUTY_WINDOW=10,
// DONE_HOLD=3). Expected values are hand-computed; power-window expectations
// follow whether COOK_SCHED_POWER_EN is defined for the build.
module tb_cook_scheduler;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cook_if bus ();

    cook_scheduler #(
        .DUTY_WINDOW (10),
        .DONE_HOLD   (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %-14s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %-14s got=%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
    endtask

    // mask bit0 = start, bit1 = stop, bit2 = clear; held low for one cycle.
    // The state change is visible when this task returns.
    task automatic press(input logic [2:0] mask);
        {bus.clearn, bus.stopn, bus.startn} = ~mask;
        step();
        {bus.clearn, bus.stopn, bus.startn} = 3'b111;
        step();
    endtask

    task automatic do_load(input logic [15:0] v);
        bus.time_in = v;
        bus.load    = 1'b1;
        step();
        bus.load    = 1'b0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_time"},    32'(bus.time_bcd),   32'h0);
        check_eq({pfx, "_mag"},     32'(bus.mag_on),     32'h0);
        check_eq({pfx, "_tdone"},   32'(bus.timer_done), 32'h0);
        check_eq({pfx, "_done"},    32'(bus.done),       32'h0);
        check_eq({pfx, "_cooking"}, 32'(bus.cooking),    32'h0);
        check_eq({pfx, "_paused"},  32'(bus.paused),     32'h0);
    endtask

    logic exp_mag;

    initial begin
        reset           = 1'b1;
        bus.tick        = 1'b0;
        bus.startn      = 1'b1;
        bus.stopn       = 1'b1;
        bus.clearn      = 1'b1;
        bus.door_closed = 1'b1;
        bus.load        = 1'b0;
        bus.time_in     = 16'h0;
`ifdef COOK_SCHED_POWER_EN
        bus.power_in    = 4'd10;
`endif
        step();
        step();
        check_reset_outputs("rst");
        reset = 1'b0;
        step();

        // 00:03 at full power, three ticks to done, then done hold.
        do_load(16'h0003);
        check_eq("load_0003", 32'(bus.time_bcd), 32'h0003);
        press(3'b001);
        check_eq("start_cook", 32'(bus.cooking), 32'h1);
        check_eq("start_mag", 32'(bus.mag_on), 32'h1);
        do_tick();
        check_eq("t1_time", 32'(bus.time_bcd), 32'h0002);
        check_eq("t1_mag", 32'(bus.mag_on), 32'h1);
        step();
        do_tick();
        check_eq("t2_time", 32'(bus.time_bcd), 32'h0001);
        check_eq("t2_mag", 32'(bus.mag_on), 32'h1);
        step();
        do_tick();
        check_eq("t3_time", 32'(bus.time_bcd), 32'h0000);
        check_eq("t3_tdone", 32'(bus.timer_done), 32'h1);
        check_eq("t3_mag", 32'(bus.mag_on), 32'h0);
        check_eq("t3_done", 32'(bus.done), 32'h1);
        step();
        check_eq("tdone_pulse", 32'(bus.timer_done), 32'h0);
        do_tick();
        check_eq("hold1_done", 32'(bus.done), 32'h1);
        do_tick();
        check_eq("hold2_done", 32'(bus.done), 32'h1);
        do_tick();
        check_eq("hold3_done", 32'(bus.done), 32'h0);
        check_eq("hold3_cook", 32'(bus.cooking), 32'h0);

        // Minute borrow 10:00 -> 09:59, pause behaviour.
        do_load(16'h1000);
        press(3'b001);
        do_tick();
        check_eq("borrow_1000", 32'(bus.time_bcd), 32'h0959);
        press(3'b010);
        check_eq("stop_paused", 32'(bus.paused), 32'h1);
        do_load(16'h0030);
        check_eq("load_in_pause", 32'(bus.time_bcd), 32'h0959);
        do_tick();
        check_eq("tick_in_pause", 32'(bus.time_bcd), 32'h0959);
        press(3'b100);
        check_eq("clr_pause_st", 32'(bus.paused), 32'h0);
        check_eq("clr_pause_tm", 32'(bus.time_bcd), 32'h0);

        // 01:00 -> 00:59; stop+start together -> PAUSE; clear -> IDLE.
        do_load(16'h0100);
        press(3'b001);
        do_tick();
        check_eq("borrow_0100", 32'(bus.time_bcd), 32'h0059);
        press(3'b011);
        check_eq("stop_start_p", 32'(bus.paused), 32'h1);
        check_eq("stop_start_c", 32'(bus.cooking), 32'h0);
        press(3'b100);
        check_eq("clear_pause", 32'(bus.time_bcd), 32'h0);
        check_eq("clear_pause_p", 32'(bus.paused), 32'h0);

        // Load validity.
        do_load(16'h0059);
        check_eq("load_0059", 32'(bus.time_bcd), 32'h0059);
        do_load(16'h0070);
        check_eq("load_0070_ign", 32'(bus.time_bcd), 32'h0059);
        do_load(16'h005A);
        check_eq("load_005A_ign", 32'(bus.time_bcd), 32'h0059);

        // Start refused with zero time or open door.
        press(3'b100);
        check_eq("idle_clear", 32'(bus.time_bcd), 32'h0);
        press(3'b001);
        check_eq("start_t0_cook", 32'(bus.cooking), 32'h0);
        check_eq("start_t0_mag", 32'(bus.mag_on), 32'h0);
        do_load(16'h0005);
        bus.door_closed = 1'b0;
        press(3'b001);
        check_eq("start_door_c", 32'(bus.cooking), 32'h0);
        check_eq("start_door_m", 32'(bus.mag_on), 32'h0);
        bus.door_closed = 1'b1;

        // Door opened mid-cook with a coincident tick.
        do_load(16'h0010);
        press(3'b001);
        for (int i = 0; i < 4; i++) begin
            do_tick();
            step();
        end
        check_eq("door_pre_time", 32'(bus.time_bcd), 32'h0006);
        check_eq("door_pre_mag", 32'(bus.mag_on), 32'h1);
        bus.door_closed = 1'b0;
        bus.tick        = 1'b1;
        #1;
        check_eq("door_mag_now", 32'(bus.mag_on), 32'h0);
        check_eq("door_cook_now", 32'(bus.cooking), 32'h1);
        @(posedge clk);
        #1;
        bus.tick = 1'b0;
        check_eq("door_paused", 32'(bus.paused), 32'h1);
        check_eq("door_time", 32'(bus.time_bcd), 32'h0006);
        bus.door_closed = 1'b1;
        step();
        press(3'b001);
        check_eq("resume_cook", 32'(bus.cooking), 32'h1);
        check_eq("resume_time", 32'(bus.time_bcd), 32'h0006);
        check_eq("resume_mag", 32'(bus.mag_on), 32'h1);
        do_tick();
        check_eq("resume_tick", 32'(bus.time_bcd), 32'h0005);
        press(3'b100);
        check_eq("clear_cook_c", 32'(bus.cooking), 32'h0);
        check_eq("clear_cook_t", 32'(bus.time_bcd), 32'h0);

        // Power 3 over two duty windows (full power without the option).
`ifdef COOK_SCHED_POWER_EN
        bus.power_in = 4'd3;
`endif
        do_load(16'h0020);
        press(3'b001);
        for (int k = 0; k < 20; k++) begin
`ifdef COOK_SCHED_POWER_EN
            exp_mag = ((k % 10) < 3);
`else
            exp_mag = 1'b1;
`endif
            check_eq($sformatf("duty_k%0d", k), 32'(bus.mag_on), 32'(exp_mag));
            do_tick();
        end
        check_eq("duty_end_done", 32'(bus.done), 32'h1);
        check_eq("duty_end_td", 32'(bus.timer_done), 32'h1);
        press(3'b100);
        check_eq("done_btn_idle", 32'(bus.done), 32'h0);

        // Reset in the middle of a cook.
`ifdef COOK_SCHED_POWER_EN
        bus.power_in = 4'd10;
`endif
        do_load(16'h0005);
        press(3'b001);
        do_tick();
        check_eq("pre_rst_time", 32'(bus.time_bcd), 32'h0004);
        reset = 1'b1;
        step();
        check_reset_outputs("rst_cook");
        reset = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
